// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the ARM32 multicycle controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_SHIFT_RD  = 3'd3,
    S_EXECUTE   = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_MOV_IMM = 7'b0000000;
  localparam logic [6:0] OP_HALT    = 7'b0000001;
  localparam logic [6:0] OP_B       = 7'b1000000;
  localparam logic [6:0] OP_BL      = 7'b1000100;
  localparam logic [6:0] OP_BX      = 7'b1000001;
  localparam logic [6:0] OP_BLX     = 7'b1000101;

  // operand type field, opcode[5:4]
  localparam logic [1:0] OPT_IMM = 2'b00;
  localparam logic [1:0] OPT_REG = 2'b01;
  localparam logic [1:0] OPT_RSH = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] SEL_PC_INC = 2'b00;
  localparam logic [1:0] SEL_PC_IMM = 2'b01;
  localparam logic [1:0] SEL_PC_RM  = 2'b10;

  localparam logic [1:0] SEL_B_RM_IMM5 = 2'b00;
  localparam logic [1:0] SEL_B_IMM12   = 2'b01;
  localparam logic [1:0] SEL_B_RM_RS   = 2'b10;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_CMP    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_ORR    = 3'b100;
  localparam logic [2:0] ALU_EOR    = 3'b101;
  localparam logic [2:0] ALU_PASS_B = 3'b111;

endpackage

// File: rtl/cpu_controller_cond_check.sv
// rtl/cpu_controller_cond_check.sv - ARM condition-code evaluation against NZCV
module cond_check
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_status,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_status[3];
  assign w_z = i_status[2];
  assign w_c = i_status[1];
  assign w_v = i_status[0];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multicycle fetch/decode/execute/writeback sequencer for the ARM32 core
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic [6:0] opcode,
  input  logic [3:0] cond,
  input  logic       en_status,
  input  logic [3:0] status,
  output logic       mem_rd_req,
  output logic       load_ir,
  output logic       load_pc,
  output logic [1:0] sel_pc,
  output logic       load_a,
  output logic       load_b,
  output logic       load_s,
  output logic [1:0] sel_b,
  output logic [2:0] alu_op,
  output logic       load_c,
  output logic       load_status,
  output logic       wb_en,
  output logic       wb_link,
  output logic       halted
);

  state_t     r_state;
  logic       w_cond_pass;
  logic       w_is_branch;
  logic       w_is_data;
  logic       w_is_cmp;
  logic       w_is_rsh;
  logic [2:0] w_alu_op;
  logic [1:0] w_sel_b;

  cond_check u_cond_check (
    .i_cond   (cond),
    .i_status (status),
    .o_pass   (w_cond_pass)
  );

  // Anything that is neither a listed branch nor a well-formed data op stops the core.
  always_comb begin
    w_is_branch = (opcode == OP_B) || (opcode == OP_BL) ||
                  (opcode == OP_BX) || (opcode == OP_BLX);
    w_is_data   = !opcode[6] && (opcode[5:4] != 2'b10) &&
                  (opcode[3] ? (opcode[2:0] != 3'b110) : (opcode[2:0] == 3'b000));
    w_is_cmp    = w_is_data && opcode[3] && (opcode[2:0] == ALU_CMP);
    w_is_rsh    = (opcode[5:4] == OPT_RSH);
    w_alu_op    = opcode[3] ? opcode[2:0] : ALU_PASS_B;
    case (opcode[5:4])
      OPT_IMM: w_sel_b = SEL_B_IMM12;
      OPT_REG: w_sel_b = SEL_B_RM_IMM5;
      default: w_sel_b = SEL_B_RM_RS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET:     r_state <= S_FETCH;
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (!w_cond_pass)     r_state <= S_FETCH;
          else if (w_is_branch) r_state <= S_EXECUTE;
          else if (!w_is_data)  r_state <= S_HALT;
          else if (w_is_rsh)    r_state <= S_SHIFT_RD;
          else                  r_state <= S_EXECUTE;
        end
        S_SHIFT_RD:  r_state <= S_EXECUTE;
        S_EXECUTE:   r_state <= w_is_branch ? S_FETCH : S_WRITEBACK;
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    mem_rd_req  = 1'b0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    sel_pc      = SEL_PC_INC;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_s      = 1'b0;
    sel_b       = SEL_B_RM_IMM5;
    alu_op      = ALU_ADD;
    load_c      = 1'b0;
    load_status = 1'b0;
    wb_en       = 1'b0;
    wb_link     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd_req = 1'b1;
        load_ir    = mem_ready;
      end
      S_DECODE: begin
        load_a  = 1'b1;
        load_b  = 1'b1;
        load_pc = 1'b1;
      end
      S_SHIFT_RD: load_s = 1'b1;
      S_EXECUTE: begin
        if (w_is_branch) begin
          // Link write uses the PC value before this edge's branch update.
          load_pc = 1'b1;
          sel_pc  = opcode[0] ? SEL_PC_RM : SEL_PC_IMM;
          wb_en   = opcode[2];
          wb_link = opcode[2];
        end else begin
          sel_b  = w_sel_b;
          alu_op = w_alu_op;
          load_c = 1'b1;
        end
      end
      S_WRITEBACK: begin
        wb_en       = !w_is_cmp;
        load_status = en_status || w_is_cmp;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic [6:0] opcode;
  logic [3:0] cond;
  logic       en_status;
  logic [3:0] status;
  logic       mem_rd_req, load_ir, load_pc, load_a, load_b, load_s;
  logic       load_c, load_status, wb_en, wb_link, halted;
  logic [1:0] sel_pc, sel_b;
  logic [2:0] alu_op;

  typedef struct packed {
    logic       rd;
    logic       ir;
    logic       pc;
    logic [1:0] spc;
    logic       a;
    logic       b;
    logic       s;
    logic [1:0] sb;
    logic [2:0] alu;
    logic       c;
    logic       st;
    logic       wb;
    logic       lk;
    logic       h;
  } ov_t;

  ov_t obs;
  ov_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  cpu_controller dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .opcode(opcode), .cond(cond),
    .en_status(en_status), .status(status), .mem_rd_req(mem_rd_req), .load_ir(load_ir),
    .load_pc(load_pc), .sel_pc(sel_pc), .load_a(load_a), .load_b(load_b), .load_s(load_s),
    .sel_b(sel_b), .alu_op(alu_op), .load_c(load_c), .load_status(load_status),
    .wb_en(wb_en), .wb_link(wb_link), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {mem_rd_req, load_ir, load_pc, sel_pc, load_a, load_b, load_s,
                sel_b, alu_op, load_c, load_status, wb_en, wb_link, halted};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Even codes test a predicate, odd codes its inverse; 14 and 15 always pass.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c >= 4'd14) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // kind: 0 data op (aop 0..5 ALU, 6 MOV; dtype 0 imm, 1 reg, 2 reg-shifted), 1 branch, 2 halt
  task automatic build(input int kind, input int aop, input int dtype, input bit link,
                       input bit breg, input bit pass, input bit en_s, input int waits);
    ov_t v;
    exp_q.delete();
    for (int i = 0; i < waits; i++) begin v = '0; v.rd = 1; exp_q.push_back(v); end
    v = '0; v.rd = 1; v.ir = 1; exp_q.push_back(v);
    v = '0; v.a = 1; v.b = 1; v.pc = 1; exp_q.push_back(v);
    if (!pass) return;
    if (kind == 2) begin
      repeat (20) begin v = '0; v.h = 1; exp_q.push_back(v); end
      return;
    end
    if (kind == 1) begin
      v = '0; v.pc = 1; v.spc = breg ? 2'b10 : 2'b01; v.wb = link; v.lk = link;
      exp_q.push_back(v);
      return;
    end
    if (dtype == 2) begin v = '0; v.s = 1; exp_q.push_back(v); end
    v = '0;
    v.sb  = (dtype == 0) ? 2'b01 : (dtype == 1) ? 2'b00 : 2'b10;
    v.alu = (aop == 6) ? 3'b111 : 3'(aop);
    v.c   = 1;
    exp_q.push_back(v);
    v = '0; v.wb = (aop != 2); v.st = en_s || (aop == 2); exp_q.push_back(v);
  endtask

  task automatic run(input string name, input int kind, input int aop, input int dtype,
                     input bit link, input bit breg, input logic [3:0] c, input bit en_s,
                     input logic [3:0] st, input int waits);
    logic [6:0] op;
    if (kind == 2)
      op = 7'b0000001;
    else if (kind == 1)
      op = 7'b1000000 | (link ? 7'b0000100 : 7'b0) | (breg ? 7'b0000001 : 7'b0);
    else
      op = {1'b0, (dtype == 0) ? 2'b00 : (dtype == 1) ? 2'b01 : 2'b11,
            (aop == 6) ? 4'b0000 : {1'b1, 3'(aop)}};
    build(kind, aop, dtype, link, breg, cond_pass(c, st), en_s, waits);
    opcode = op; cond = c; en_status = en_s; status = st;
    foreach (exp_q[i]) begin
      if (i < waits)       mem_ready = 1'b0;
      else if (i == waits) mem_ready = 1'b1;
      else                 mem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), obs, exp_q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid_exec();
    ov_t v;
    opcode = 7'b0011000; cond = 4'hE; en_status = 1'b0; status = 4'($urandom); mem_ready = 1'b1;
    @(negedge clk); v = '0; v.rd = 1; v.ir = 1; check("rx_fetch", obs, v);
    @(posedge clk); #1;
    @(negedge clk); v = '0; v.a = 1; v.b = 1; v.pc = 1; check("rx_decode", obs, v);
    @(posedge clk); #1;
    @(negedge clk); v = '0; v.c = 1; check("rx_exec", obs, v);
    #1 rst = 1'b1;
    #1 check("rx_async_drop", obs, 18'h0);
    @(posedge clk); #1 check("rx_held", obs, 18'h0);
    @(negedge clk); #2 rst = 1'b0;
    #1 check("rx_release", obs, 18'h0);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); v = '0; v.rd = 1; check("rx_fetch_again", obs, v);
    @(posedge clk); #1;
  endtask

  initial begin
    ov_t v;
    int  kind;
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; cond = '0; en_status = 1'b0; status = '0;
    repeat (2) @(negedge clk);
    check("reset_state", obs, 18'h0);
    #2 rst = 1'b0;
    #1 check("reset_release", obs, 18'h0);
    @(posedge clk); #1;

    reset_mid_exec();

    run("add_reg",   0, 0, 1, 0, 0, 4'hE, 0, 4'($urandom), 2);
    run("cmp_imm",   0, 2, 0, 0, 0, 4'hE, 0, 4'($urandom), 0);
    run("eor_rsh",   0, 5, 2, 0, 0, 4'hE, 0, 4'($urandom), 0);
    run("b_eq_fail", 1, 0, 0, 0, 0, 4'h0, 0, 4'b0000, 0);
    run("b_eq_pass", 1, 0, 0, 0, 0, 4'h0, 0, 4'b0100, 0);
    run("blx",       1, 0, 0, 1, 1, 4'hE, 0, 4'($urandom), 1);
    run("nop",       0, 6, 0, 0, 0, 4'hF, 1, 4'($urandom), 0);

    for (int k = 0; k < 300; k++) begin
      kind = ($urandom_range(0, 9) < 7) ? 0 : 1;
      run($sformatf("rnd%0d", k), kind, $urandom_range(0, 6), $urandom_range(0, 2),
          1'($urandom), 1'($urandom),
          $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15)),
          1'($urandom), 4'($urandom), $urandom_range(0, 3));
    end

    run("halt", 2, 0, 0, 0, 0, 4'hE, 0, 4'($urandom), 1);

    @(negedge clk); v = '0; v.h = 1; check("halt_sticky", obs, v);
    #2 rst = 1'b1;
    #1 check("halt_rst_drop", obs, 18'h0);
    @(negedge clk); #2 rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); v = '0; v.rd = 1; check("halt_rst_fetch", obs, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multicycle control FSM for the ARM32 CPU core. It sequences instruction fetch, decode, register read, execute and writeback around the instruction decoder, register file, shifter/ALU and PC. It consumes the decoder's `opcode`, `cond` and `en_status` fields plus the NZCV status register, and drives every datapath load/select strobe. It also handles the instruction-memory read handshake.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_ready`  in  1  instruction memory has valid data this cycle.
- `opcode`  in  7  decoder opcode (from IR).
- `cond`  in  4  decoder condition field.
- `en_status`  in  1  decoder S bit.
- `status`  in  4  NZCV flags, {N,Z,C,V}.
- `mem_rd_req`  out  1  instruction read request.
- `load_ir`  out  1  latch instruction register.
- `load_pc`  out  1  write PC.
- `sel_pc`  out  2  PC source: 00 PC+4, 01 PC+imm24 target, 10 register B (rm).
- `load_a`, `load_b`, `load_s`  out  1 each  latch rn, rm, rs read values.
- `sel_b`  out  2  operand B: 00 rm shifted by imm5, 01 imm12, 10 rm shifted by rs.
- `alu_op`  out  3  000 ADD, 001 SUB, 010 CMP, 011 AND, 100 ORR, 101 EOR, 111 pass-B (MOV).
- `load_c`  out  1  latch ALU result.
- `load_status`  out  1  write NZCV.
- `wb_en`  out  1  register-file write.
- `wb_link`  out  1  write PC to r14 instead of C to rd.
- `halted`  out  1  core stopped.

## Operation
- States: RESET, FETCH, DECODE, SHIFT_RD, EXECUTE, WRITEBACK, HALT.
- Opcode classes:
  - opcode[6]=1: branch. 1000000 B, 1000100 BL, 1000001 BX, 1000101 BLX.
  - 0000001: HALT.
  - Data ops: opcode[5:4] gives operand type (00 imm, 01 reg, 11 reg-shifted). opcode[3]=1 means ALU with alu_op=opcode[2:0]; opcode[3]=0 means MOV (alu_op=111).
  - 0000000 is MOV imm; NOP decodes to it and is harmless.
  - Any other opcode: HALT.
- RESET → FETCH unconditionally.
- FETCH:
  - `mem_rd_req`=1.
  - Stay in FETCH while `mem_ready`=0.
  - On `mem_ready`=1: `load_ir`=1, go to DECODE.
- DECODE:
  - `load_a`=`load_b`=1, `load_pc`=1 with `sel_pc`=00.
  - Evaluate `cond` against `status` using the ARM table: EQ..LE; AL=1110; 1111 passes.
  - Condition fail → FETCH.
  - Condition pass: HALT opcode → HALT; reg-shifted class → SHIFT_RD; else → EXECUTE.
- SHIFT_RD: `load_s`=1, go to EXECUTE.
- EXECUTE, data op:
  - `sel_b` from class, `alu_op` as above, `load_c`=1.
  - Go to WRITEBACK.
- EXECUTE, branch:
  - `load_pc`=1; `sel_pc`=01 for B/BL, 10 for BX/BLX.
  - BL/BLX also assert `wb_en`=`wb_link`=1 in the same cycle; the register file samples the pre-edge PC.
  - Go to FETCH.
- WRITEBACK:
  - `wb_en`=1 unless opcode is CMP.
  - `load_status`=`en_status` OR CMP.
  - Go to FETCH.
- HALT: `halted`=1, all strobes 0; sticky until `rst`.

## Timing
- Outputs are combinational functions of the state and the current decoder inputs (Moore plus decoded opcode); none are registered.
- In RESET, every output is 0, `halted`=0.
- `rst` asserted in any state, mid-instruction or while waiting on memory: state → RESET immediately and all strobes drop the same instant. A memory request in flight is abandoned.
- `mem_ready` is ignored outside FETCH.
- Latency, with `mem_ready` high on the first FETCH cycle:
  - data reg/imm: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK);
  - reg-shifted: 5;
  - branch: 3;
  - condition-failed: 2.
- Each extra cycle of `mem_ready`=0 adds one FETCH cycle.
- A `status` write in WRITEBACK is visible to the next DECODE (at least 2 cycles later).

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum (3-bit);
  - opcode constants;
  - cond-code constants;
  - `sel_pc`, `sel_b` and `alu_op` encodings.
- Sub-module `cond_check`: combinational, (cond, status) → pass. Instantiated once.

## Test plan
1. Hold `rst`=1 mid-EXECUTE → all outputs 0 immediately. Release → RESET, then FETCH next cycle with `mem_rd_req`=1.
2. ADD reg (0011000, cond 1110), `mem_ready` low 2 cycles then high:
   - `load_ir` on 3rd FETCH cycle;
   - DECODE: `load_a`,`load_b`,`load_pc`/`sel_pc`=00;
   - EXECUTE: `alu_op`=000, `sel_b`=00, `load_c`;
   - WRITEBACK: `wb_en`=1, `load_status`=0.
3. CMP imm 0001010, `en_status`=0 → EXECUTE `sel_b`=01, `alu_op`=010; WRITEBACK `load_status`=1, `wb_en`=0.
4. EOR reg-shifted 0111101 → SHIFT_RD asserts `load_s`; EXECUTE `sel_b`=10, `alu_op`=101; total 5 cycles.
5. B with cond 0000:
   - `status`=0000 → DECODE then FETCH, no EXECUTE;
   - `status`=0100 → EXECUTE `load_pc`=1, `sel_pc`=01.
6. BLX 1000101 → EXECUTE `load_pc`,`sel_pc`=10,`wb_en`,`wb_link` all 1. Then HALT 0000001 → `halted`=1 for 20 cycles with `mem_rd_req`=0 until `rst`.
